// File: rtl/fifo_ctrl_sync.sv
// Single-clock FIFO controller: RAM address/enable generation, occupancy count,
// threshold flags and overflow/underflow pulses, with synchronous flush.
module fifo_ctrl_sync #(
   parameter int unsigned  DEPTH    = 8,
   parameter int unsigned  AF_LEVEL = 7,
   parameter int unsigned  AE_LEVEL = 1,
   localparam int unsigned AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wen,
   input  logic          ren,
   input  logic          flush,
   output logic          wr_en_mem,
   output logic          rd_en_mem,
   output logic [AW-1:0] w_addr,
   output logic [AW-1:0] r_addr,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          overflow,
   output logic          underflow
);

   logic [AW-1:0] w_addr_q, w_addr_d;
   logic [AW-1:0] r_addr_q, r_addr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, empty_q, afull_q, aempty_q, ovf_q, unf_q;
   logic          wr_acc, rd_acc;

   assign wr_acc = wen & ~full_q & ~flush;
   assign rd_acc = ren & ~empty_q & ~flush;

   // Pointers wrap explicitly at DEPTH-1 so non-power-of-2 depths never reach DEPTH.
   always_comb begin
      w_addr_d = w_addr_q;
      r_addr_d = r_addr_q;
      if (wr_acc) w_addr_d = (w_addr_q == AW'(DEPTH - 1)) ? '0 : w_addr_q + AW'(1);
      if (rd_acc) r_addr_d = (r_addr_q == AW'(DEPTH - 1)) ? '0 : r_addr_q + AW'(1);
   end

   always_comb begin
      count_d = count_q;
      if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_addr_q <= '0;
         r_addr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else if (flush) begin
         w_addr_q <= '0;
         r_addr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         // Flags derive from the next count so they align with the count register.
         w_addr_q <= w_addr_d;
         r_addr_q <= r_addr_d;
         count_q  <= count_d;
         full_q   <= (count_d == CW'(DEPTH));
         empty_q  <= (count_d == '0);
         afull_q  <= (count_d >= CW'(AF_LEVEL));
         aempty_q <= (count_d <= CW'(AE_LEVEL));
         ovf_q    <= wen & full_q;
         unf_q    <= ren & empty_q;
      end
   end

   assign wr_en_mem    = wr_acc;
   assign rd_en_mem    = rd_acc;
   assign w_addr       = w_addr_q;
   assign r_addr       = r_addr_q;
   assign count        = count_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign almost_full  = afull_q;
   assign almost_empty = aempty_q;
   assign overflow     = ovf_q;
   assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// Bench for fifo_ctrl_sync (DEPTH=5, AF=4, AE=1): directed literal checks plus
// randomized traffic compared every cycle against an occupancy/pointer model.
module tb_fifo_ctrl_sync;

   localparam int DEPTH = 5;
   localparam int AF    = 4;
   localparam int AE    = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wen = 1'b0, ren = 1'b0, flush = 1'b0;
   logic       wr_en_mem, rd_en_mem;
   logic [2:0] w_addr, r_addr, count;
   logic       full, empty, almost_full, almost_empty, overflow, underflow;

   int tests = 0;
   int fails = 0;

   fifo_ctrl_sync #(.DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
      .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .flush(flush),
      .wr_en_mem(wr_en_mem), .rd_en_mem(rd_en_mem),
      .w_addr(w_addr), .r_addr(r_addr), .count(count),
      .full(full), .empty(empty), .almost_full(almost_full),
      .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // Reference model: occupancy integer and modulo-DEPTH pointers.
   int m_count = 0, m_wp = 0, m_rp = 0;
   bit m_ovf = 0, m_unf = 0;
   bit m_wacc, m_racc;
   assign m_wacc = wen && (m_count != DEPTH) && !flush;
   assign m_racc = ren && (m_count != 0) && !flush;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         m_count <= 0; m_wp <= 0; m_rp <= 0; m_ovf <= 0; m_unf <= 0;
      end else begin
         m_count <= m_count + int'(m_wacc) - int'(m_racc);
         m_wp    <= m_wacc ? (m_wp + 1) % DEPTH : m_wp;
         m_rp    <= m_racc ? (m_rp + 1) % DEPTH : m_rp;
         m_ovf   <= wen && (m_count == DEPTH);
         m_unf   <= ren && (m_count == 0);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      check("m.wr_en_mem", wr_en_mem, m_wacc);
      check("m.rd_en_mem", rd_en_mem, m_racc);
      check("m.count", count, m_count);
      check("m.w_addr", w_addr, m_wp);
      check("m.r_addr", r_addr, m_rp);
      check("m.full", full, m_count == DEPTH);
      check("m.empty", empty, m_count == 0);
      check("m.almost_full", almost_full, m_count >= AF);
      check("m.almost_empty", almost_empty, m_count <= AE);
      check("m.overflow", overflow, m_ovf);
      check("m.underflow", underflow, m_unf);
   end

   task automatic step(input bit w, input bit r, input bit f);
      wen = w; ren = r; flush = f;
      @(posedge clk); #1;
      wen = 0; ren = 0; flush = 0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (3) step(0, 0, 0);
      check("idle.count", count, 0);
      check("idle.w_addr", w_addr, 0);
      check("idle.r_addr", r_addr, 0);
      check("idle.empty", empty, 1);
      check("idle.almost_empty", almost_empty, 1);
      check("idle.full", full, 0);
      check("idle.almost_full", almost_full, 0);
      check("idle.overflow", overflow, 0);
      check("idle.underflow", underflow, 0);

      for (int i = 1; i <= 5; i++) begin
         step(1, 0, 0);
         check("fill.count", count, i);
         check("fill.w_addr", w_addr, i % 5);
         check("fill.almost_full", almost_full, i >= 4);
         check("fill.full", full, i == 5);
      end
      wen = 1; #1;
      check("fill6.wr_en_mem", wr_en_mem, 0);
      @(posedge clk); #1; wen = 0;
      check("fill6.overflow", overflow, 1);
      check("fill6.count", count, 5);
      step(0, 0, 0);
      check("fill6.overflow_clear", overflow, 0);

      for (int i = 1; i <= 5; i++) begin
         step(0, 1, 0);
         check("drain.count", count, 5 - i);
         check("drain.r_addr", r_addr, i % 5);
         check("drain.almost_empty", almost_empty, (5 - i) <= 1);
         check("drain.empty", empty, i == 5);
      end
      ren = 1; #1;
      check("drain6.rd_en_mem", rd_en_mem, 0);
      @(posedge clk); #1; ren = 0;
      check("drain6.underflow", underflow, 1);
      step(0, 0, 0);
      check("drain6.underflow_clear", underflow, 0);

      step(1, 1, 0);
      check("sim_empty.count", count, 1);
      check("sim_empty.underflow", underflow, 1);
      repeat (4) step(1, 0, 0);
      check("sim_full.pre", full, 1);
      step(1, 1, 0);
      check("sim_full.count", count, 4);
      check("sim_full.overflow", overflow, 1);
      step(0, 1, 0);
      step(0, 1, 0);
      check("sim_mid.pre", count, 2);
      step(1, 1, 0);
      check("sim_mid.count", count, 2);
      check("sim_mid.w_addr", w_addr, 1);
      check("sim_mid.r_addr", r_addr, 4);

      repeat (3) step(1, 0, 0);
      wen = 1; ren = 1; flush = 1; #1;
      check("flush.wr_en_mem", wr_en_mem, 0);
      check("flush.rd_en_mem", rd_en_mem, 0);
      @(posedge clk); #1; wen = 0; ren = 0; flush = 0;
      check("flush.count", count, 0);
      check("flush.w_addr", w_addr, 0);
      check("flush.r_addr", r_addr, 0);
      check("flush.empty", empty, 1);
      check("flush.overflow", overflow, 0);
      check("flush.underflow", underflow, 0);

      for (int i = 0; i < 20; i++) begin
         step(i % 2 == 0, i % 2 == 1, 0);
         check("wrap.count", count, (i % 2 == 0) ? 1 : 0);
         check("wrap.full", full, 0);
      end
      check("wrap.w_addr", w_addr, 0);

      step(1, 0, 0);
      step(1, 0, 0);
      wen = 1; #2;
      rst_n = 1'b0; #1;
      check("arst.count", count, 0);
      check("arst.w_addr", w_addr, 0);
      check("arst.empty", empty, 1);
      check("arst.almost_empty", almost_empty, 1);
      wen = 0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      for (int ph = 0; ph < 8; ph++) begin
         for (int c = 0; c < 250; c++) begin
            int wb;
            wb    = (ph % 2 == 0) ? 75 : 25;
            wen   = ($urandom_range(99) < wb);
            ren   = ($urandom_range(99) < 100 - wb);
            flush = ($urandom_range(99) < 2);
            if ($urandom_range(199) == 0) begin
               #2 rst_n = 1'b0; #1;
               check("rnd.arst.count", count, 0);
               @(negedge clk) rst_n = 1'b1;
            end
            @(posedge clk); #1;
         end
      end
      wen = 0; ren = 0; flush = 0;
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
